// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer driving PC and pipeline-register enables for the 5-stage pipeline
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_stall,
  input  logic             dmem_busy,
  input  logic             idex_mem_read,
  input  logic             idex_rd_valid,
  input  logic [2:0]       idex_rd,
  input  logic [2:0]       ifid_rs,
  input  logic             ifid_rs_used,
  input  logic [2:0]       ifid_rt,
  input  logic             ifid_rt_used,
  input  logic             ex_redirect,
  input  logic             idex_halt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_t;
  state_t state_q, state_d, base;
  logic redir_pend_q, redir_pend_d, drain_ret_q, drain_ret_d, lu, drain;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
    {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '0;
    halted = 1'b0;
    state_d = state_q;
    redir_pend_d = redir_pend_q;
    drain_ret_d = drain_ret_q;
    lu = idex_mem_read && idex_rd_valid &&
         ((ifid_rs_used && ifid_rs == idex_rd) || (ifid_rt_used && ifid_rt == idex_rd));
    // once memory is done, MEM_WAIT behaves exactly like the state it interrupted
    base = (state_q == MEM_WAIT) ? (drain_ret_q ? DRAIN : RUN) : state_q;
    drain = base == DRAIN;
    if (base == HALTED) halted = 1'b1;
    else if (dmem_busy) begin
      memwb_en = 1'b1;
      memwb_flush = 1'b1;
      state_d = MEM_WAIT;
      drain_ret_d = drain;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
      state_d = base;
      if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        redir_pend_d = if_stall;
      end else if (lu && !drain) begin
        pc_en = 1'b0;
        ifid_en = 1'b0;
        idex_flush = 1'b1;
      end else if (if_stall || redir_pend_q) begin
        pc_en = 1'b0;
        ifid_flush = 1'b1;
        redir_pend_d = redir_pend_q && if_stall;
      end
      if (drain) begin
        pc_en = 1'b0;
        ifid_flush = 1'b1;
        state_d = memwb_halt ? HALTED : DRAIN;
      end else if (idex_halt && !ex_redirect) state_d = DRAIN;
    end
    if (!rst) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '0;
      halted = 1'b0;
    end
    stall_cnt_d = (state_q != HALTED && !pc_en && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      redir_pend_q <= 1'b0;
      drain_ret_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      redir_pend_q <= redir_pend_d;
      drain_ret_q <= drain_ret_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed enables, flushes and stall counts
module tb_pipe_ctrl;
  logic clk = 1'b0, rst;
  logic if_stall, dmem_busy, idex_mem_read, idex_rd_valid, ifid_rs_used, ifid_rt_used;
  logic ex_redirect, idex_halt, memwb_halt;
  logic [2:0] idex_rd, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
  logic [15:0] stall_cnt;
  logic s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halted;
  logic [3:0] s_stall_cnt;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .if_stall(if_stall), .dmem_busy(dmem_busy),
    .idex_mem_read(idex_mem_read), .idex_rd_valid(idex_rd_valid), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used), .ifid_rt(ifid_rt), .ifid_rt_used(ifid_rt_used),
    .ex_redirect(ex_redirect), .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .halted(halted), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_stall(if_stall), .dmem_busy(dmem_busy),
    .idex_mem_read(idex_mem_read), .idex_rd_valid(idex_rd_valid), .idex_rd(idex_rd),
    .ifid_rs(ifid_rs), .ifid_rs_used(ifid_rs_used), .ifid_rt(ifid_rt), .ifid_rt_used(ifid_rt_used),
    .ex_redirect(ex_redirect), .idex_halt(idex_halt), .memwb_halt(memwb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
    .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
    .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halted(s_halted),
    .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // en = {pc,ifid,idex,exmem,memwb}, fl = {ifid,idex,exmem,memwb}
  task automatic check_ctl(input string tag, input logic [4:0] en, input logic [3:0] fl, input logic h);
    #1;
    check({tag, ".en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
    check({tag, ".fl"}, {28'd0, ifid_flush, idex_flush, exmem_flush, memwb_flush}, {28'd0, fl});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {if_stall, dmem_busy, idex_mem_read, idex_rd_valid, ifid_rs_used, ifid_rt_used} = '0;
    {ex_redirect, idex_halt, memwb_halt} = '0;
    idex_rd = 3'd0;
    ifid_rs = 3'd0;
    ifid_rt = 3'd0;
  endtask

  task automatic set_lu(input logic rs_used);
    idex_mem_read = 1'b1;
    idex_rd_valid = 1'b1;
    idex_rd = 3'd3;
    ifid_rs = 3'd3;
    ifid_rs_used = rs_used;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    cyc();
    cyc();
    check_ctl("reset", 5'b00000, 4'b0000, 1'b0);
    check("reset.cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b1;
    check_ctl("post_reset", 5'b11111, 4'b0000, 1'b0);
    cyc();
    set_lu(1'b1);
    check_ctl("lu", 5'b00111, 4'b0100, 1'b0);
    cyc();
    idle();
    check("lu.cnt", 32'(stall_cnt), 32'd1);
    check_ctl("lu.after", 5'b11111, 4'b0000, 1'b0);
    set_lu(1'b0);
    check_ctl("lu.unused", 5'b11111, 4'b0000, 1'b0);
    cyc();
    idle();
    check("lu.unused.cnt", 32'(stall_cnt), 32'd1);
    ex_redirect = 1'b1;
    if_stall = 1'b1;
    check_ctl("redir", 5'b11111, 4'b1100, 1'b0);
    cyc();
    ex_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_stall = (i < 2);
      check_ctl($sformatf("redir.pend%0d", i), 5'b01111, 4'b1000, 1'b0);
      cyc();
    end
    idle();
    check_ctl("redir.done", 5'b11111, 4'b0000, 1'b0);
    check("redir.cnt", 32'(stall_cnt), 32'd4);
    set_lu(1'b1);
    ex_redirect = 1'b1;
    dmem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_ctl($sformatf("dmem%0d", i), 5'b00001, 4'b0001, 1'b0);
      cyc();
    end
    dmem_busy = 1'b0;
    check_ctl("dmem.release", 5'b11111, 4'b1100, 1'b0);
    check("dmem.cnt", 32'(stall_cnt), 32'd8);
    cyc();
    idle();
    idex_halt = 1'b1;
    check_ctl("halt.run", 5'b11111, 4'b0000, 1'b0);
    cyc();
    idex_halt = 1'b0;
    check_ctl("halt.drain0", 5'b01111, 4'b1000, 1'b0);
    cyc();
    memwb_halt = 1'b1;
    check_ctl("halt.drain1", 5'b01111, 4'b1000, 1'b0);
    cyc();
    memwb_halt = 1'b0;
    check_ctl("halted", 5'b00000, 4'b0000, 1'b1);
    check("halted.cnt", 32'(stall_cnt), 32'd10);
    if_stall = 1'b1;
    repeat (3) cyc();
    check_ctl("halted.hold", 5'b00000, 4'b0000, 1'b1);
    check("halted.cnt_frozen", 32'(stall_cnt), 32'd10);
    idle();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    idex_halt = 1'b1;
    ex_redirect = 1'b1;
    check_ctl("halt_kill", 5'b11111, 4'b1100, 1'b0);
    cyc();
    idle();
    check_ctl("halt_kill.run", 5'b11111, 4'b0000, 1'b0);
    check("halt_kill.cnt", 32'(stall_cnt), 32'd0);
    if_stall = 1'b1;
    repeat (20) cyc();
    check("sat.cnt4", 32'(s_stall_cnt), 32'd15);
    check("sat.cnt16", 32'(stall_cnt), 32'd20);
    repeat (2) cyc();
    check("sat.hold", 32'(s_stall_cnt), 32'd15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
